param_group_rotator: RTL
========================

// Module: param_group_rotator
// PURPOSE
// Parametrised successor of the fault-correction circular shifter. Rotates a row of
// NUM_GROUPS words (GROUP_W bits each) left/right by a runtime step, or passes it
// through. Sits between the FSM controller and the Br/Cf row buffers. Adds valid/ready
// handshake, modulo step reduction, step-error flag, hold timeout, flush.
// PARAMETERS
// GROUP_W      32   bits per group
// NUM_GROUPS   33   groups per row; >=2
// STEP_W       $clog2(NUM_GROUPS)  step width; fixed, so step < 2*NUM_GROUPS always
// HOLD_CYCLES  6    max cycles out_valid waits for out_ready; 0 = wait forever
// PORTS
// clk        in   1                  clock, rising edge
// rst_n      in   1                  asynchronous, active-low reset
// flush      in   1                  sync abort: return to IDLE, drop held result
// in_valid   in   1                  request valid
// in_ready   out  1                  block can accept request (IDLE only)
// in_data    in   GROUP_W*NUM_GROUPS row; group k = in_data[GROUP_W*k +: GROUP_W]
// in_dir     in   1                  1: rotate toward higher index; 0: toward lower
// in_step    in   STEP_W             rotate amount in groups
// in_bypass  in   1                  1: out = in, dir/step ignored, no step_err
// out_valid  out  1                  result valid
// out_ready  in   1                  consumer accepts result
// out_data   out  GROUP_W*NUM_GROUPS rotated row
// out_step_err out 1                 in_step >= NUM_GROUPS (qualified by out_valid)
// out_drop   out  1                  1-cycle pulse: result discarded on timeout
// BEHAVIOUR
// - Reset: state IDLE; in_ready=1; out_valid=0; out_data=0; out_step_err=0; out_drop=0.
// - FSM IDLE -> CALC on in_valid&&in_ready: capture data/dir/bypass, s = in_step mod
//   NUM_GROUPS (single conditional subtract), err = (in_step>=NUM_GROUPS)&&!in_bypass.
// - CALC -> VALID next cycle: out_data registered. dir=1: out[k]=in[(k-s) mod N];
//   dir=0: out[k]=in[(k+s) mod N]; bypass or s==0: out=in. out_valid=1 in VALID only.
// - Latency: accept edge to out_valid high = 2 cycles. Throughput 1 row / 3+ cycles.
// - VALID -> IDLE on out_ready (handshake). If HOLD_CYCLES>0 and out_ready stays low
//   HOLD_CYCLES cycles in VALID: -> IDLE, out_drop pulses 1 cycle with the exit.
// - out_ready on the timeout cycle: handshake wins, no out_drop.
// - out_data/out_step_err hold stable while out_valid=1; retain last value in IDLE.
// - in_ready=0 in CALC and VALID; in_valid there is ignored (no queueing).
// - flush: highest priority, any state -> IDLE next cycle, out_valid low, no out_drop.
//   flush with in_valid in IDLE: request not accepted.
// - rst_n low mid-operation: immediate return to reset values; no partial output.
// STRUCTURE
// - Package mm_ft_pkg: DIR_UP=1'b1, DIR_DOWN=1'b0, state enum {IDLE,CALC,VALID}.
// - Sub-module group_rotate (combinational, params GROUP_W/NUM_GROUPS/STEP_W):
//   data+dir+reduced step -> rotated row; wrapper holds FSM, regs, timeout counter.
// - Timeout counter width $clog2(HOLD_CYCLES+1); omitted via generate when 0.
// TESTING (GROUP_W=32, NUM_GROUPS=33, HOLD_CYCLES=6; group k loaded with k)
// 1 dir=1 step=1 out_ready=1 -> 2 cycles later out_valid; out[0]=32, out[1]=0, out[32]=31.
// 2 dir=0 step=32 -> out[0]=32, out[1]=0; step=40 -> same as step=7, out_step_err=1.
// 3 bypass=1 step=50 -> out[k]=k for all k, out_step_err=0; step=0 dir=0 -> out=in.
// 4 out_ready held 0 -> out_valid high exactly 6 cycles, out_drop 1 cycle, in_ready
//   returns; repeat with out_ready on 6th cycle -> no out_drop.
// 5 flush in CALC and in VALID -> IDLE next cycle, out_valid never/no longer high;
//   in_valid pulses during CALC/VALID not accepted.
// 6 rst_n low during VALID -> out_valid=0, out_data=0 immediately; next request normal.

Source files
------------

// File: rtl/mm_ft_pkg.sv
// ---------------------------------------------------------------------------
// mm_ft_pkg
// Shared definitions for the parametrised group rotator and its sub-module.
//   DIR_UP   : rotate toward higher group index
//   DIR_DOWN : rotate toward lower group index
//   state_t  : control FSM states (IDLE -> CALC -> VALID)
// ---------------------------------------------------------------------------
package mm_ft_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        VALID = 2'd2
    } state_t;

endpackage

// File: rtl/group_rotate.sv
// ---------------------------------------------------------------------------
// group_rotate
// Combinational circular shifter over NUM_GROUPS words of GROUP_W bits.
// Ports:
//   i_data : input row, group k = i_data[GROUP_W*k +: GROUP_W]
//   i_dir  : DIR_UP moves group k to k+step, DIR_DOWN moves it to k-step
//   i_step : rotate amount, must already be reduced below NUM_GROUPS
//   o_data : rotated row
// ---------------------------------------------------------------------------
module group_rotate
    import mm_ft_pkg::*;
#(
    parameter int GROUP_W    = 32,
    parameter int NUM_GROUPS = 33,
    parameter int STEP_W     = $clog2(NUM_GROUPS)
) (
    input  logic [GROUP_W*NUM_GROUPS-1:0] i_data,
    input  logic                          i_dir,
    input  logic [STEP_W-1:0]             i_step,
    output logic [GROUP_W*NUM_GROUPS-1:0] o_data
);

    // Each output group picks its source group; the wrap is a single
    // add/subtract of NUM_GROUPS because the step is already reduced.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < NUM_GROUPS; k++) begin
            int src;
            if (i_dir == DIR_UP) begin
                src = (k >= int'(i_step)) ? (k - int'(i_step))
                                          : (k - int'(i_step) + NUM_GROUPS);
            end else begin
                src = (k + int'(i_step) < NUM_GROUPS) ? (k + int'(i_step))
                                                      : (k + int'(i_step) - NUM_GROUPS);
            end
            o_data[GROUP_W*k +: GROUP_W] = i_data[GROUP_W*src +: GROUP_W];
        end
    end

endmodule

// File: rtl/param_group_rotator.sv
// ---------------------------------------------------------------------------
// param_group_rotator
// Rotates a row of NUM_GROUPS words left/right by a runtime step (or passes
// it through) behind a valid/ready handshake. One request in flight at a
// time: IDLE accepts, CALC registers the rotated row, VALID presents it.
// Ports:
//   i_clk, i_rst_n   : clock (rising edge), asynchronous active-low reset
//   i_flush          : synchronous abort to IDLE, held result is dropped
//   i_in_valid/o_in_ready : request handshake (ready only in IDLE)
//   i_in_data        : input row
//   i_in_dir         : 1 rotate toward higher index, 0 toward lower
//   i_in_step        : rotate amount in groups (reduced modulo NUM_GROUPS)
//   i_in_bypass      : pass row through unchanged, no step error
//   o_out_valid/i_out_ready : result handshake
//   o_out_data       : rotated row, stable while valid, kept in IDLE
//   o_out_step_err   : requested step was >= NUM_GROUPS
//   o_out_drop       : one-cycle pulse when a result times out unconsumed
// ---------------------------------------------------------------------------
module param_group_rotator
    import mm_ft_pkg::*;
#(
    parameter  int GROUP_W     = 32,
    parameter  int NUM_GROUPS  = 33,
    parameter  int HOLD_CYCLES = 6,
    localparam int STEP_W      = $clog2(NUM_GROUPS),
    localparam int ROW_W       = GROUP_W * NUM_GROUPS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [ROW_W-1:0]  i_in_data,
    input  logic              i_in_dir,
    input  logic [STEP_W-1:0] i_in_step,
    input  logic              i_in_bypass,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ROW_W-1:0]  o_out_data,
    output logic              o_out_step_err,
    output logic              o_out_drop
);

    state_t             r_state;
    state_t             w_nextState;
    logic [ROW_W-1:0]   r_inData;
    logic [ROW_W-1:0]   r_outData;
    logic [ROW_W-1:0]   w_rotData;
    logic               r_dir;
    logic [STEP_W-1:0]  r_step;
    logic               r_err;
    logic               r_outErr;
    logic               r_drop;
    logic               w_stepOver;
    logic [STEP_W-1:0]  w_stepRed;
    logic               w_accept;
    logic               w_timeout;

    // The compare is one bit wider so a power-of-two NUM_GROUPS does not
    // truncate to zero; the subtract itself is exact modulo 2^STEP_W.
    assign w_stepOver = ({1'b0, i_in_step} >= (STEP_W + 1)'(NUM_GROUPS));
    assign w_stepRed  = w_stepOver ? (i_in_step - STEP_W'(NUM_GROUPS)) : i_in_step;
    assign w_accept   = (r_state == IDLE) && i_in_valid && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Handshake beats timeout when out_ready arrives on the last hold cycle;
    // flush overrides everything.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = CALC;
            CALC:    w_nextState = VALID;
            VALID:   if (i_out_ready || w_timeout) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        if (i_flush) begin
            w_nextState = IDLE;
        end
    end

    // Bypass is folded into a zero step so the rotator needs no extra mux.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inData <= '0;
            r_dir    <= DIR_DOWN;
            r_step   <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_inData <= i_in_data;
            r_dir    <= i_in_dir;
            r_step   <= i_in_bypass ? '0 : w_stepRed;
            r_err    <= w_stepOver && !i_in_bypass;
        end
    end

    group_rotate #(
        .GROUP_W    (GROUP_W),
        .NUM_GROUPS (NUM_GROUPS),
        .STEP_W     (STEP_W)
    ) u_group_rotate (
        .i_data (r_inData),
        .i_dir  (r_dir),
        .i_step (r_step),
        .o_data (w_rotData)
    );

    // Output registers only load when leaving CALC, which keeps them stable
    // through VALID and retained in IDLE; a flush in CALC leaves them alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outData <= '0;
            r_outErr  <= 1'b0;
        end else if ((r_state == CALC) && !i_flush) begin
            r_outData <= w_rotData;
            r_outErr  <= r_err;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= (r_state == VALID) && w_timeout && !i_out_ready && !i_flush;
        end
    end

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
            logic [CNT_W-1:0] r_holdCnt;

            // Counts cycles spent in VALID; the last allowed cycle is HOLD_CYCLES-1.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_holdCnt <= '0;
                end else if ((r_state != VALID) || i_flush) begin
                    r_holdCnt <= '0;
                end else begin
                    r_holdCnt <= r_holdCnt + CNT_W'(1);
                end
            end

            assign w_timeout = (r_state == VALID) && (r_holdCnt == CNT_W'(HOLD_CYCLES - 1));
        end else begin : g_no_hold
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign o_in_ready     = (r_state == IDLE);
    assign o_out_valid    = (r_state == VALID);
    assign o_out_data     = r_outData;
    assign o_out_step_err = r_outErr;
    assign o_out_drop     = r_drop;

endmodule
